dma_io_peripheral: RTL

DMA_IO_PERIPHERAL -- requirements
Module: dma_io_peripheral

---
 rtl/dma_io_peripheral.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dma_io_peripheral.sv
// Byte FIFO bridging an 8237-style DMA handshake (DREQ/DACK, IOR/IOW strobes, EOP)
// to a local valid/ready push/pop port; direction selects which side fills the FIFO.
module dma_io_peripheral #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic          DREQ,
    input  logic          DACK,
    input  logic          nIOR,
    input  logic          nIOW,
    input  logic          nEOP,
    input  logic          Dir,
    input  logic [7:0]    DataIn,
    output logic [7:0]    DataOut,
    output logic          DataOutEn,
    input  logic [7:0]    LocalWrData,
    input  logic          LocalWrValid,
    output logic          LocalWrReady,
    output logic [7:0]    LocalRdData,
    output logic          LocalRdValid,
    input  logic          LocalRdReady,
    input  logic          Restart,
    output logic [CW-1:0] Count,
    output logic          Done,
    output logic          Underrun
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          dreq_r, dreq_nxt_s;
    logic          underrun_r;
    logic          dir_r, dir_nxt_s;
    logic          ior_q_r, iow_q_r;
    logic [7:0]    iow_data_r;

    logic          empty_s, full_s, xfer_ack_s, eop_s;
    logic          ior_edge_s, iow_edge_s;
    logic          local_push_s, local_pop_s, dma_push_s, dma_pop_s;
    logic          push_s, pop_s, underrun_set_s;
    logic [7:0]    push_data_s;

    function automatic logic ready_f(input logic dir, input logic [CW-1:0] cnt);
        return dir ? (cnt != FULL) : (cnt != {CW{1'b0}});
    endfunction

    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == FULL);
    assign xfer_ack_s = (state_r == XFER) && DACK;
    assign eop_s      = DACK && !nEOP;

    // A strobe completes on its rising edge; only honoured during an acknowledged transfer.
    assign ior_edge_s = xfer_ack_s && !dir_r && !ior_q_r && nIOR;
    assign iow_edge_s = xfer_ack_s &&  dir_r && !iow_q_r && nIOW;

    // A full FIFO still accepts a push in the same cycle the other side pops.
    assign dma_pop_s      = ior_edge_s && !empty_s;
    assign local_pop_s    = dir_r && !empty_s && LocalRdReady;
    assign LocalWrReady   = !dir_r && (!full_s || dma_pop_s);
    assign local_push_s   = LocalWrValid && LocalWrReady;
    assign dma_push_s     = iow_edge_s && (!full_s || local_pop_s);
    assign underrun_set_s = (ior_edge_s && empty_s) || (iow_edge_s && full_s && !local_pop_s);

    assign push_s      = local_push_s || dma_push_s;
    assign pop_s       = local_pop_s || dma_pop_s;
    assign push_data_s = dir_r ? iow_data_r : LocalWrData;

    assign DataOutEn    = DACK && !nIOR && !Dir;
    assign DataOut      = empty_s ? 8'hFF : mem_r[rd_ptr_r];
    assign LocalRdData  = mem_r[rd_ptr_r];
    assign LocalRdValid = dir_r && !empty_s;
    assign Count        = count_r;
    assign Done         = (state_r == DONE);
    assign Underrun     = underrun_r;
    assign DREQ         = dreq_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Direction is only re-latched while no transfer is in flight.
    always_comb begin
        dir_nxt_s = dir_r;
        if (state_r == IDLE || state_r == DONE) begin
            dir_nxt_s = Dir;
        end else begin
            dir_nxt_s = dir_r;
        end
    end

    // Handshake state transitions; EOP takes priority over Restart.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (eop_s)                       state_nxt_s = DONE;
                else if (ready_f(dir_r, count_r)) state_nxt_s = REQ;
                else                             state_nxt_s = IDLE;
            end
            REQ: begin
                if (eop_s)     state_nxt_s = DONE;
                else if (DACK) state_nxt_s = XFER;
                else           state_nxt_s = REQ;
            end
            XFER: begin
                if (eop_s)      state_nxt_s = DONE;
                else if (!DACK) state_nxt_s = IDLE;
                else            state_nxt_s = XFER;
            end
            DONE: begin
                if (Restart && !eop_s) state_nxt_s = IDLE;
                else                   state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // DREQ looks ahead at the post-update occupancy so it drops on the last edge.
    always_comb begin
        dreq_nxt_s = 1'b0;
        if (state_nxt_s == REQ) begin
            dreq_nxt_s = 1'b1;
        end else if (state_nxt_s == XFER) begin
            dreq_nxt_s = ready_f(dir_nxt_s, count_nxt_s);
        end else begin
            dreq_nxt_s = 1'b0;
        end
    end

    // Control, pointer and strobe-history registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= IDLE;
            dreq_r     <= 1'b0;
            count_r    <= {CW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            underrun_r <= 1'b0;
            dir_r      <= Dir;
            ior_q_r    <= 1'b1;
            iow_q_r    <= 1'b1;
            iow_data_r <= 8'h00;
        end else begin
            state_r  <= state_nxt_s;
            dreq_r   <= dreq_nxt_s;
            count_r  <= count_nxt_s;
            dir_r    <= dir_nxt_s;
            ior_q_r  <= nIOR;
            iow_q_r  <= nIOW;
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            if (!nIOW)  iow_data_r <= DataIn;
            if (underrun_set_s)  underrun_r <= 1'b1;
            else if (Restart)    underrun_r <= 1'b0;
        end
    end

    // FIFO storage; contents are invalidated by the occupancy reset, not cleared.
    always_ff @(posedge Clock) begin
        if (push_s) mem_r[wr_ptr_r] <= push_data_s;
    end

endmodule
